spi_slave_rx: RTL

- Dual-lane SPI frame receiver. Sits directly downstream of the simulation SPI master, on the consuming FPGA/board.
- Oversamples SSEL, SCK, DATA_IN0 and DATA_IN1 on the local clk and deserialises two parallel MSB-first 32-bit words per frame.
- Presents both words with a one-cycle valid strobe and returns a status/echo word on MISO.

---
 rtl/spi_slave_rx_if.sv | 24 ++
 rtl/spi_slave_rx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Serial bus between an SPI master and the dual-lane frame receiver.
interface spi_slave_rx_if;
    logic SSEL;
    logic SCK;
    logic DATA_IN0;
    logic DATA_IN1;
    logic MISO;

    modport master (
        output SSEL,
        output SCK,
        output DATA_IN0,
        output DATA_IN1,
        input  MISO
    );

    modport slave (
        input  SSEL,
        input  SCK,
        input  DATA_IN0,
        input  DATA_IN1,
        output MISO
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Dual-lane SPI frame receiver: oversamples the bus on clk, deserialises two
// MSB-first words per frame and echoes tx_data back on MISO.
module spi_slave_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    spi_slave_rx_if.slave         spi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data0,
    output logic [DATA_WIDTH-1:0] rx_data1,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam logic [BW-1:0] BIT_FULL = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_SAT  = BW'(DATA_WIDTH + 1);
    // Bit order inside the synchroniser vectors: {DATA_IN1, DATA_IN0, SCK, SSEL}
    localparam logic [3:0] SYNC_INIT = 4'b0001;

    typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;

    logic [3:0] raw;
    logic [3:0] s1_reg;
    logic [3:0] s2_reg;
    logic [1:0] s3_reg;
    logic [1:0] rise;
    logic [1:0] fall;

    assign raw = {spi.DATA_IN1, spi.DATA_IN0, spi.SCK, spi.SSEL};

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_reg <= SYNC_INIT;
            s2_reg <= SYNC_INIT;
            s3_reg <= SYNC_INIT[1:0];
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg[1:0];
        end
    end

    // Only SSEL and SCK need edges; data lanes are read straight from s2 so
    // they line up with the SCK edge seen at the same stage.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            assign rise[gi] =  s2_reg[gi] & ~s3_reg[gi];
            assign fall[gi] = ~s2_reg[gi] &  s3_reg[gi];
        end
    endgenerate

    logic ssel_rise, ssel_fall, sck_rise, sck_fall;
    assign ssel_rise = rise[0];
    assign ssel_fall = fall[0];
    assign sck_rise  = rise[1];
    assign sck_fall  = fall[1];

    state_t                  state_reg;
    logic [BW-1:0]           bitcnt_reg;
    logic [DATA_WIDTH-1:0]   sh0_reg;
    logic [DATA_WIDTH-1:0]   sh1_reg;
    logic [DATA_WIDTH-2:0]   tx_sh_reg;
    logic                    miso_reg;
    logic [DATA_WIDTH-1:0]   rx_data0_reg;
    logic [DATA_WIDTH-1:0]   rx_data1_reg;
    logic                    rx_valid_reg;
    logic                    frame_err_reg;
    logic [CNT_WIDTH-1:0]    frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= '0;
            sh0_reg       <= '0;
            sh1_reg       <= '0;
            tx_sh_reg     <= '0;
            miso_reg      <= 1'b0;
            rx_data0_reg  <= '0;
            rx_data1_reg  <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (!en) begin
                state_reg <= IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        miso_reg <= 1'b0;
                        if (ssel_fall) begin
                            bitcnt_reg <= '0;
                            sh0_reg    <= '0;
                            sh1_reg    <= '0;
                            // MISO holds the current MSB; tx_sh_reg keeps the rest
                            miso_reg   <= tx_data[DATA_WIDTH-1];
                            tx_sh_reg  <= tx_data[DATA_WIDTH-2:0];
                            state_reg  <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (ssel_rise) begin
                            miso_reg  <= 1'b0;
                            state_reg <= CHECK;
                        end else begin
                            if (sck_rise) begin
                                sh0_reg <= {sh0_reg[DATA_WIDTH-2:0], s2_reg[2]};
                                sh1_reg <= {sh1_reg[DATA_WIDTH-2:0], s2_reg[3]};
                                if (bitcnt_reg != BIT_SAT)
                                    bitcnt_reg <= bitcnt_reg + BW'(1);
                            end
                            if (sck_fall) begin
                                miso_reg  <= tx_sh_reg[DATA_WIDTH-2];
                                tx_sh_reg <= {tx_sh_reg[DATA_WIDTH-3:0], 1'b0};
                            end
                        end
                    end
                    CHECK: begin
                        state_reg <= IDLE;
                        if (bitcnt_reg == BIT_FULL) begin
                            rx_data0_reg  <= sh0_reg;
                            rx_data1_reg  <= sh1_reg;
                            rx_valid_reg  <= 1'b1;
                            frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign spi.MISO  = miso_reg;
    assign rx_data0  = rx_data0_reg;
    assign rx_data1  = rx_data1_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
